// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller for an external comparator
// Optional feature: SAR_EARLY_EXIT_EN ends the search as soon as the comparator reports equality.
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] TOP_INDEX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TEST = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] trial_q, trial_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    index_q, index_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] decided;
   logic             keep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         trial_q  <= '0;
         result_q <= '0;
         index_q  <= TOP_INDEX;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         index_q  <= index_d;
         err_q    <= err_d;
      end
   end

   // A simultaneous gt/eq is inconsistent but still treated as a keep.
   always_comb begin
      state_d  = state_q;
      trial_d  = trial_q;
      result_d = result_q;
      index_d  = index_q;
      err_d    = err_q;
      keep     = cmp_gt | cmp_eq;
      decided  = trial_q;
      if (!keep) begin
         decided[index_q] = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d           = TEST;
               trial_d           = '0;
               trial_d[WIDTH-1]  = 1'b1;
               index_d           = TOP_INDEX;
               err_d             = 1'b0;
            end
         end
         TEST: begin
            if (cmp_gt && cmp_eq) begin
               err_d = 1'b1;
            end
`ifdef SAR_EARLY_EXIT_EN
            if (cmp_eq) begin
               result_d = trial_q;
               state_d  = DONE;
            end else
`endif
            if (index_q == '0) begin
               result_d = decided;
               trial_d  = decided;
               state_d  = DONE;
            end else begin
               trial_d              = decided;
               trial_d[index_q - 1'b1] = 1'b1;
               index_d              = index_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign trial  = trial_q;
   assign result = result_q;
   assign err    = err_q;
   assign busy   = (state_q == TEST);
   assign done   = (state_q == DONE);

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the trial code and the result.
REQ-002 Port: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  begin a search; sampled only in IDLE.
REQ-005 Port: cmp_gt  input  1  from the external comparator; high when target > trial.
REQ-006 Port: cmp_eq  input  1  from the external comparator; high when target == trial.
REQ-007 Port: trial  output  WIDTH  registered candidate code driven to the comparator's second operand.
REQ-008 Port: busy  output  1  high while in TEST.
REQ-009 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 Port: result  output  WIDTH  final code, held until the next accepted start.
REQ-011 Port: err  output  1  sticky comparator-inconsistency flag; cleared on the next accepted start.

Function
REQ-012 States SHALL be IDLE, TEST and DONE, encoded in a registered state variable.
REQ-013 IDLE with start=1 at a clock edge SHALL go to TEST, load trial = MSB set and all other bits 0, set bit index = WIDTH-1, clear err, and leave result unchanged.
REQ-014 TEST SHALL make one bit decision per cycle by sampling cmp_gt/cmp_eq against the current trial, treating the comparator as combinational within that cycle.
REQ-015 Bit decision: if cmp_gt|cmp_eq, keep the current bit at 1; otherwise clear it.
REQ-016 Next trial: if index > 0, set bit index-1 and decrement index.
REQ-017 At index 0: register the decided value into result, drive trial with that same value, and go to DONE.
REQ-018 Latency SHALL be WIDTH TEST cycles; done SHALL be high exactly in cycle WIDTH+1 after the start edge.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE; start in DONE SHALL be ignored.
REQ-020 start while busy SHALL be ignored, with no restart and no effect on trial.
REQ-021 trial SHALL hold its last value in IDLE and DONE.
REQ-022 cmp_gt=1 and cmp_eq=1 in the same TEST cycle SHALL set err=1; the decision SHALL treat it as a keep, and the search SHALL continue.
REQ-023 Arithmetic is unsigned; results span 0 to 2^WIDTH-1 with no wrap; target 0 SHALL yield result 0 with no bit ever kept.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, trial=0, result=0, busy=0, done=0, err=0, index=WIDTH-1, regardless of state.
REQ-025 Reset asserted mid-search SHALL abort the search with no done pulse; the first start after rst_n rises SHALL run a complete, correct search.

Configuration
REQ-026 Macro SAR_EARLY_EXIT_EN defined: cmp_eq=1 in any TEST cycle SHALL load result=trial, go to DONE next, and pulse done, skipping the remaining bits; lower bits of result SHALL be 0.
REQ-027 Macro SAR_EARLY_EXIT_EN undefined: every search SHALL take exactly WIDTH TEST cycles regardless of cmp_eq; cmp_eq SHALL be used only in the keep decision and the err check.

Verification (bench comparator model: cmp_gt = target > trial, cmp_eq = target == trial; WIDTH=4)
REQ-028 Target 11, start at cycle 0 -> trial sequence 8, 12, 10, 11; done in cycle 5; result=11; err=0.
REQ-029 Targets 0 and 15 -> trial sequences 8,4,2,1 and 8,12,14,15; results 0 and 15; done in cycle 5.
REQ-030 Target 8 -> with SAR_EARLY_EXIT_EN, done in cycle 2 and result=8; without it, done in cycle 5 and result=8.
REQ-031 Start pulsed again in cycles 2 and 5 of a target-6 search -> no restart; result=6; single done pulse; next start from IDLE is accepted.
REQ-032 rst_n low in cycle 2 of a search -> trial=0, busy=0, done never pulses; start after release with target 5 -> result=5.
REQ-033 Bench forces cmp_gt=cmp_eq=1 on the first trial -> err=1 until the next accepted start; MSB kept.
